mul_tree_collector: RTL

//  Downstream stage of mul_tree. Captures the per-lane 32-bit float products from mul_tree.outputs.

---
 rtl/mul_tree_collector.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mul_tree_collector.sv
// Collects per-lane float products from mul_tree into one record per mode mask and
// queues completed records in a first-word-fall-through FIFO with valid/ready output.
module mul_tree_collector #(
    parameter int LANES = 4,
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [LANES*WIDTH-1:0] mul_outputs,
    input  logic [LANES-1:0]       mul_stbs,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [LANES*WIDTH-1:0] res_data,
    output logic [LANES-1:0]       res_mask,
    output logic                   busy,
    output logic                   err_dup,
    output logic                   err_lane,
    output logic                   err_ovf,
    input  logic                   clr_err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [LANES-1:0][WIDTH-1:0] in_lane;
    logic [LANES-1:0][WIDTH-1:0] dat_q, dat_d, rec_data;
    logic [LANES-1:0]            cap_q, cap_d, mask_q, mask_d;
    logic [LANES-1:0]            mode_mask, eff_mask, hit, next_cap, dup;
    logic                        idle, complete, set_dup, set_lane, set_ovf;

    logic [DEPTH-1:0][LANES*WIDTH-1:0] mem_data_q;
    logic [DEPTH-1:0][LANES-1:0]       mem_mask_q;
    logic [PW-1:0]                     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                     count_q, count_d;
    logic                              full, push, pop;
    logic                              err_dup_q, err_lane_q, err_ovf_q;

    assign in_lane = mul_outputs;

    // Mode n enables lanes 0..n (thermometer mask).
    for (genvar k = 0; k < LANES; k++) begin : g_mode
        assign mode_mask[k] = (int'(mode) >= k);
    end

    assign idle     = (cap_q == '0);
    assign eff_mask = idle ? mode_mask : mask_q;
    assign hit      = mul_stbs & eff_mask;
    assign next_cap = cap_q | hit;
    assign complete = (next_cap == eff_mask);
    assign dup      = hit & cap_q;

    always_comb begin
        rec_data = '0;
        dat_d    = dat_q;
        for (int k = 0; k < LANES; k++) begin
            if (eff_mask[k])
                rec_data[k] = cap_q[k] ? dat_q[k] : in_lane[k];
            // On completion, re-strobed lanes seed the next record.
            if (hit[k] && (complete || !cap_q[k]))
                dat_d[k] = in_lane[k];
        end
        cap_d    = complete ? dup : next_cap;
        mask_d   = (idle && (mul_stbs != '0)) ? mode_mask : mask_q;
        set_dup  = (dup != '0) && !complete;
        set_lane = (mul_stbs & ~eff_mask) != '0;
    end

    assign full    = (count_q == CW'(DEPTH));
    assign pop     = res_valid && res_ready;
    assign push    = complete && (!full || pop);
    assign set_ovf = complete && full && !pop;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_q      <= '0;
            mask_q     <= '0;
            dat_q      <= '0;
            mem_data_q <= '0;
            mem_mask_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_dup_q  <= 1'b0;
            err_lane_q <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            cap_q   <= cap_d;
            mask_q  <= mask_d;
            dat_q   <= dat_d;
            count_q <= count_d;
            if (push) begin
                mem_data_q[wr_ptr_q] <= rec_data;
                mem_mask_q[wr_ptr_q] <= eff_mask;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            // A fresh error in the clearing cycle keeps its flag set.
            err_dup_q  <= (err_dup_q  && !clr_err) || set_dup;
            err_lane_q <= (err_lane_q && !clr_err) || set_lane;
            err_ovf_q  <= (err_ovf_q  && !clr_err) || set_ovf;
        end
    end

    assign res_valid = (count_q != '0);
    assign busy      = full;
    assign res_data  = res_valid ? mem_data_q[rd_ptr_q] : '0;
    assign res_mask  = res_valid ? mem_mask_q[rd_ptr_q] : '0;
    assign err_dup   = err_dup_q;
    assign err_lane  = err_lane_q;
    assign err_ovf   = err_ovf_q;
endmodule
